// File: rtl/alu_arbiter_if.sv
// Request/response and ALU-drive bundle for alu_arbiter.
// The slave modport is the arbiter side; the master modport is the requesters plus the ALU.
interface alu_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
);
  logic             req_valid_0, req_ready_0;
  logic [OPW-1:0]   req_op_0;
  logic [WIDTH-1:0] req_a_0, req_b_0;
  logic             req_valid_1, req_ready_1;
  logic [OPW-1:0]   req_op_1;
  logic [WIDTH-1:0] req_a_1, req_b_1;
  logic             rsp_valid_0, rsp_valid_1;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero, rsp_err;
  logic [OPW-1:0]   alu_ctrl;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;

  modport slave (
    input  req_valid_0, req_op_0, req_a_0, req_b_0,
    input  req_valid_1, req_op_1, req_a_1, req_b_1, alu_result,
    output req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1,
    output rsp_result, rsp_zero, rsp_err, alu_ctrl, alu_a, alu_b
  );

  modport master (
    output req_valid_0, req_op_0, req_a_0, req_b_0,
    output req_valid_1, req_op_1, req_a_1, req_b_1, alu_result,
    input  req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1,
    input  rsp_result, rsp_zero, rsp_err, alu_ctrl, alu_a, alu_b
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin share of the E-stage ALU between two requesters; issue then capture, 2 cycles per op.
// Optional ALU_ILLEGAL_OP_TRAP_EN: ops 3-5 and 11-15 are trapped and answered with rsp_err.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input logic         clk,
  input logic         reset,
  alu_arbiter_if.slave bus
);
  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                      state, nstate;
  logic                        last_grant, owner, grant, take, take_ill, cap_ill;
  logic [1:0]                  vld, rsp_vld;
  logic [1:0][OPW-1:0]         op;
  logic [1:0][WIDTH-1:0]       opa, opb;
  logic [OPW-1:0]              ctrl_q;
  logic [WIDTH-1:0]            a_q, b_q, res_q;
  logic                        zero_q;

  assign vld = {bus.req_valid_1, bus.req_valid_0};
  assign op  = {bus.req_op_1, bus.req_op_0};
  assign opa = {bus.req_a_1, bus.req_a_0};
  assign opb = {bus.req_b_1, bus.req_b_0};

  always_comb begin
    nstate = state;
    take   = 1'b0;
    grant  = 1'b0;
    case (state)
      IDLE: if (|vld) begin
        take   = 1'b1;
        // on a tie the port that did not win last time goes next
        grant  = (&vld) ? ~last_grant : vld[1];
        nstate = ISSUE;
      end
      ISSUE:   nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  assign bus.req_ready_0 = take & ~grant;
  assign bus.req_ready_1 = take & grant;

`ifdef ALU_ILLEGAL_OP_TRAP_EN
  logic ill_q, err_q;
  assign take_ill = (op[grant] inside {OPW'(3), OPW'(4), OPW'(5)}) || (op[grant] >= OPW'(11));
  assign cap_ill  = ill_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ill_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (take) ill_q <= take_ill;
      if (state == ISSUE) err_q <= ill_q;
    end
  end
  assign bus.rsp_err = err_q;
`else
  assign take_ill    = 1'b0;
  assign cap_ill     = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      ctrl_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      zero_q     <= 1'b0;
      rsp_vld    <= '0;
    end else begin
      state   <= nstate;
      rsp_vld <= '0;
      if (take) begin
        last_grant <= grant;
        owner      <= grant;
        // trapped ops leave the ALU inputs untouched
        if (!take_ill) begin
          ctrl_q <= op[grant];
          a_q    <= opa[grant];
          b_q    <= opb[grant];
        end
      end
      if (state == ISSUE) begin
        rsp_vld[owner] <= 1'b1;
        res_q          <= cap_ill ? '0 : bus.alu_result;
        zero_q         <= cap_ill | (bus.alu_result == '0);
      end
    end
  end

  assign bus.alu_ctrl    = ctrl_q;
  assign bus.alu_a       = a_q;
  assign bus.alu_b       = b_q;
  assign bus.rsp_result  = res_q;
  assign bus.rsp_zero    = zero_q;
  assign bus.rsp_valid_0 = rsp_vld[0];
  assign bus.rsp_valid_1 = rsp_vld[1];
endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized + directed bench for alu_arbiter against a transaction-level arbitration/ALU model.
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   total = 0, bad = 0;

  alu_arbiter_if #(.WIDTH(32), .OPW(4)) bus ();
  alu_arbiter #(.WIDTH(32), .OPW(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    case (o)
      4'd0:    return x & y;
      4'd1:    return x | y;
      4'd2:    return x + y;
      4'd6:    return x - y;
      4'd7:    return {31'b0, $signed(x) < $signed(y)};
      4'd10:   return ~(x | y);
      default: return x ^ y;
    endcase
  endfunction

  assign bus.alu_result = alu_fn(bus.alu_ctrl, bus.alu_a, bus.alu_b);

  function automatic bit illegal(input logic [3:0] o);
`ifdef ALU_ILLEGAL_OP_TRAP_EN
    return (o == 3 || o == 4 || o == 5 || o >= 11);
`else
    return 1'b0;
`endif
  endfunction

  // requester-side stimulus
  logic        v[2];
  logic [3:0]  op[2];
  logic [31:0] a[2], b[2];

  // model state
  int          last, ip, wt[2];
  bit          busy, infl;
  logic [31:0] e_res, h_res, m_a, m_b;
  logic        e_zero, e_err, h_zero, h_err;
  logic [3:0]  m_ctrl;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    bus.req_valid_0 = v[0]; bus.req_op_0 = op[0]; bus.req_a_0 = a[0]; bus.req_b_0 = b[0];
    bus.req_valid_1 = v[1]; bus.req_op_1 = op[1]; bus.req_a_1 = a[1]; bus.req_b_1 = b[1];
  endtask

  task automatic set_req(input int p, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    v[p] = 1'b1; op[p] = o; a[p] = x; b[p] = y;
  endtask

  // one clock: check readies before the edge, responses and ALU drive after it
  task automatic step();
    int         acc;
    logic [1:0] er;
    drive();
    #1;
    er = 2'b00;
    if (!busy) begin
      if (v[0] && v[1]) er[last == 1 ? 0 : 1] = 1'b1;
      else if (v[0])    er[0] = 1'b1;
      else if (v[1])    er[1] = 1'b1;
    end
    chk("ready0", bus.req_ready_0, er[0]);
    chk("ready1", bus.req_ready_1, er[1]);
    acc = er[0] ? 0 : (er[1] ? 1 : -1);
    for (int x = 0; x < 2; x++) if (v[x] && acc != x) wt[x]++;
    @(negedge clk);
    if (infl) begin h_res = e_res; h_zero = e_zero; h_err = e_err; end
    chk("rsp_valid0", bus.rsp_valid_0, infl && ip == 0);
    chk("rsp_valid1", bus.rsp_valid_1, infl && ip == 1);
    chk("rsp_result", bus.rsp_result, h_res);
    chk("rsp_zero", bus.rsp_zero, h_zero);
    chk("rsp_err", bus.rsp_err, h_err);
    infl = 1'b0;
    if (acc >= 0) begin
      if (illegal(op[acc])) begin
        e_res = 0; e_zero = 1'b1; e_err = 1'b1;
      end else begin
        m_ctrl = op[acc]; m_a = a[acc]; m_b = b[acc];
        e_res = alu_fn(op[acc], a[acc], b[acc]); e_zero = (e_res == 0); e_err = 1'b0;
      end
      infl = 1'b1; ip = acc; last = acc; v[acc] = 1'b0;
      chk("fair_wait", wt[acc] <= 3, 1);
      wt[acc] = 0;
    end
    chk("alu_ctrl", bus.alu_ctrl, m_ctrl);
    chk("alu_a", bus.alu_a, m_a);
    chk("alu_b", bus.alu_b, m_b);
    busy = (acc >= 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_rsp_valid0", bus.rsp_valid_0, 0);
    chk("rst_rsp_valid1", bus.rsp_valid_1, 0);
    chk("rst_rsp_result", bus.rsp_result, 0);
    chk("rst_rsp_zero", bus.rsp_zero, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_alu_ctrl", bus.alu_ctrl, 0);
    chk("rst_alu_a", bus.alu_a, 0);
    chk("rst_alu_b", bus.alu_b, 0);
    @(negedge clk);
    chk("rst_hold_valid0", bus.rsp_valid_0, 0);
    reset = 1'b0;
    last = 1; busy = 1'b0; infl = 1'b0; ip = 0;
    h_res = 0; h_zero = 1'b0; h_err = 1'b0;
    m_ctrl = 0; m_a = 0; m_b = 0;
    e_res = 0; e_zero = 1'b0; e_err = 1'b0;
    for (int x = 0; x < 2; x++) begin v[x] = 1'b0; op[x] = 0; a[x] = 0; b[x] = 0; wt[x] = 0; end
    drive();
  endtask

  initial begin
    for (int x = 0; x < 2; x++) begin v[x] = 1'b0; op[x] = 0; a[x] = 0; b[x] = 0; end
    drive();
    do_reset();

    // single port ADD
    set_req(0, 4'd2, 32'd5, 32'd7); step(); step();
    chk("single_add", bus.rsp_result, 32'd12);

    // reset while the op is in ISSUE: it must vanish
    set_req(0, 4'd2, 32'd5, 32'd7); step();
    do_reset();
    step();
    // port 0 wins the first tie after reset
    set_req(0, 4'd0, 32'hFF, 32'h0F); set_req(1, 4'd1, 32'h1, 32'h2); step();
    step(); step(); step();

    // contention: both held valid, grants must alternate
    for (int i = 0; i < 10; i++) begin
      set_req(0, 4'd6, 32'd9, 32'd9);
      set_req(1, 4'd1, 32'hF0, 32'h0F);
      step();
    end
    step(); step();

    // late request on port 1 arriving during ISSUE
    set_req(0, 4'd2, 32'd1, 32'd1); step();
    set_req(1, 4'd2, 32'd100, 32'd23); step();
    step(); step();

    // pass-through ops on port 1
    set_req(1, 4'd7, 32'd3, 32'd8); step(); step();
    chk("slt", bus.rsp_result, 32'd1);
    set_req(1, 4'd10, 32'd0, 32'd0); step(); step();
    chk("nor", bus.rsp_result, 32'hFFFF_FFFF);

    // op 4: trapped or forwarded depending on build
    set_req(0, 4'd4, 32'd6, 32'd3); step(); step();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      for (int x = 0; x < 2; x++) begin
        if (!v[x] && $urandom_range(2) == 0) begin
          set_req(x, 4'($urandom_range(15)),
                  ($urandom_range(3) == 0) ? 32'd0 : 32'($urandom),
                  ($urandom_range(3) == 0) ? 32'd0 : 32'($urandom));
        end
      end
      step();
    end
    v[0] = 1'b0; v[1] = 1'b0;
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single E-stage ALU between two requesters: port 0 (main pipeline E stage) and port 1 (auxiliary unit, e.g. address/branch compare).
- Each port uses a valid/ready request handshake and receives a one-cycle response pulse.
- Round-robin arbitration. ALU drive signals are registered. Result and zero flag are captured from the ALU one cycle after issue.

Parameters:
- WIDTH, 32, operand/result width
- OPW, 4, ALU control value width

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid_0  input  1  port 0 request valid
- req_ready_0  output  1  port 0 request accepted this cycle
- req_op_0  input  OPW  port 0 ALU control value
- req_a_0  input  WIDTH  port 0 operand one
- req_b_0  input  WIDTH  port 0 operand two
- req_valid_1, req_ready_1, req_op_1, req_a_1, req_b_1  as above, port 1
- rsp_valid_0  output  1  one-cycle pulse, port 0 result ready
- rsp_valid_1  output  1  one-cycle pulse, port 1 result ready
- rsp_result  output  WIDTH  captured result, shared by both ports
- rsp_zero  output  1  1 when rsp_result == 0
- rsp_err  output  1  illegal-op flag (only with the optional feature)
- alu_ctrl  output  OPW  to ALU control value
- alu_a  output  WIDTH  to ALU operand one
- alu_b  output  WIDTH  to ALU operand two
- alu_result  input  WIDTH  from ALU result

Behaviour:
- Reset (async):
  - state=IDLE, last_grant=1 (port 0 wins the first tie).
  - alu_ctrl/alu_a/alu_b=0.
  - rsp_result=0, rsp_zero=0, rsp_err=0, rsp_valid_0/1=0.
  - Reset during ISSUE drops the operation; no response is produced.
- States: IDLE, ISSUE.
- Grant (combinational, IDLE only):
  - Only one port valid: grant that port.
  - Both valid: grant the port != last_grant.
  - req_ready_x=1 only for the granted port. Both readies are 0 outside IDLE.
- Handshake:
  - Transfer when req_valid_x & req_ready_x at a rising edge.
  - On that edge: alu_ctrl/alu_a/alu_b <= granted op/a/b; last_grant <= x; owner <= x; state <= ISSUE.
  - Requester must hold valid and payload stable until ready. Payload may change after transfer.
- ISSUE (exactly one cycle):
  - On the next edge: rsp_result <= alu_result; rsp_zero <= (alu_result==0); rsp_valid_owner <= 1 for one cycle; state <= IDLE.
  - rsp_zero is computed from the captured value, never from an ALU flag.
- Latency and throughput:
  - Accept at edge N, rsp_valid high during cycle after edge N+1.
  - One operation per 2 cycles. A new grant may occur in the same cycle rsp_valid is high.
- rsp_result/rsp_zero hold their value until the next capture.
- rsp_valid_0 and rsp_valid_1 are never high together.
- Op codes are passed through unmodified. Width rules are the ALU's. The arbiter does no arithmetic.
- Requests arriving in ISSUE wait. No request is lost or duplicated.
- A port held valid continuously is served at least every 4 cycles under contention.

Optional Feature:
- Macro: ALU_ILLEGAL_OP_TRAP_EN.
- Defined:
  - Ops 3, 4, 5 and 11-15 are illegal.
  - They are still accepted via the normal handshake and take the same 2-cycle timing.
  - alu_ctrl/alu_a/alu_b are not updated.
  - Response: rsp_result=0, rsp_zero=1, rsp_err=1.
  - Legal ops give rsp_err=0.
- Undefined: all op codes are forwarded verbatim; rsp_err is tied to 0.

Test Plan:
- Reset mid-ISSUE:
  - Stimulus: port 0 ADD a=5, b=7 accepted; reset asserted next cycle.
  - Response: no rsp_valid_0; all outputs 0; after release, port 0 wins the first tie.
- Single port:
  - Stimulus: port 0 ADD(2) a=5, b=7.
  - Response: req_ready_0 same cycle; alu_ctrl=2, alu_a=5, alu_b=7 after edge; rsp_valid_0 one cycle later, rsp_result=12, rsp_zero=0.
- Contention:
  - Stimulus: both ports valid continuously, port 0 SUB(6) 9-9, port 1 OR(1) 0xF0|0x0F.
  - Response: grants alternate 0,1,0,1; port 0 rsp_result=0, rsp_zero=1; port 1 rsp_result=0xFF; no overlapping rsp_valid.
- Late request:
  - Stimulus: port 1 raises valid during ISSUE of a port 0 op.
  - Response: req_ready_1=0 that cycle, granted the next IDLE cycle; payload held and served exactly once.
- Pass-through ops:
  - Stimulus: SLT(7) a=3, b=8, then NOR(10) a=0, b=0 on port 1.
  - Response: rsp_result=1, then 0xFFFFFFFF.
- With ALU_ILLEGAL_OP_TRAP_EN:
  - Stimulus: op=4 on port 0.
  - Response: rsp_err=1, rsp_result=0, rsp_zero=1, alu_ctrl unchanged.
  - Without the macro: same stimulus gives alu_ctrl=4, rsp_err=0.
